// File: rtl/snn_spike_aer_encoder.sv
// snn_spike_aer_encoder: serializes each step's spike vector into an ascending-index
// AER event stream with step timestamps and a saturating dropped-step counter.
module snn_spike_aer_encoder #(
    parameter int N   = 96,
    parameter int TSW = 16,
    parameter int DCW = 16,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           ts_clear,
    input  logic           step_valid,
    input  logic [N-1:0]   spikes_vec,
    output logic           step_ready,
    output logic           aer_valid,
    input  logic           aer_ready,
    output logic [AW-1:0]  aer_addr,
    output logic [TSW-1:0] aer_ts,
    output logic           aer_last,
    output logic [DCW-1:0] drop_cnt
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d, pend_clr;
    logic [TSW-1:0] ts_cnt_q, ts_cnt_d, ts_cap_q, ts_cap_d;
    logic [DCW-1:0] drop_q, drop_d;

    assign pend_clr   = pend_q & (pend_q - 1'b1);
    assign step_ready = (state_q == IDLE);
    assign aer_valid  = (state_q == SCAN);
    assign aer_last   = aer_valid && (pend_clr == '0);
    assign aer_ts     = ts_cap_q;
    assign drop_cnt   = drop_q;

    // Scanning downward leaves the lowest set bit as the final winner.
    always_comb begin
        aer_addr = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pend_q[i]) aer_addr = AW'(i);
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ts_cnt_d = ts_cnt_q;
        ts_cap_d = ts_cap_q;
        drop_d   = drop_q;
        if (ts_clear) begin
            ts_cnt_d = '0;
            drop_d   = '0;
        end else if (step_valid) begin
            ts_cnt_d = ts_cnt_q + 1'b1;
            if (state_q == IDLE) begin
                pend_d   = spikes_vec;
                ts_cap_d = ts_cnt_q;
                state_d  = (|spikes_vec) ? SCAN : IDLE;
            end else if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end
        if (aer_valid && aer_ready) begin
            pend_d  = pend_clr;
            state_d = aer_last ? IDLE : SCAN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            ts_cnt_q <= '0;
            ts_cap_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            ts_cnt_q <= ts_cnt_d;
            ts_cap_q <= ts_cap_d;
            drop_q   <= drop_d;
        end
    end

endmodule
